// File: rtl/mem_bus_responder.sv
// Data-memory responder for the multicycle core's load/store bus.
// Four-phase req/ack handshake with programmable wait states.
module mem_bus_responder #(
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be within 0..15");
    end
    if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
        $error("DEPTH must be within 1..2**ADDR_W");
    end

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdata_q;
    logic [15:0]         rdata_q;
    logic                ack_q;
    logic                err_q;
    logic [15:0]         mem_q [DEPTH];

    logic                acc_we;
    logic [ADDR_W-1:0]   acc_addr;
    logic [15:0]         acc_wdata;
    logic [IDX_W-1:0]    acc_idx;
    logic                in_range;
    logic                access;

    // A zero-wait access happens on the sampling edge, before the latches fill.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
        end
    end

    assign acc_idx  = acc_addr[IDX_W-1:0];
    assign in_range = {1'b0, acc_addr} < DEPTH_L;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = WAIT_L;
                    state_d = (WAIT_L == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        access = (state_q != S_ACK) && (state_d == S_ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && req) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (access) begin
                ack_q <= 1'b1;
                err_q <= !in_range;
                if (!in_range) begin
                    rdata_q <= 16'h0000;
                end else if (!acc_we) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end else if (state_q == S_ACK && !req) begin
                ack_q <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_we && in_range) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: random transactions against a
// transaction-level model, plus directed literal checks.
module tb_mem_bus_responder;

    localparam int W = 2;
    localparam int D = 128;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        a_req, a_we, a_ack, a_err, a_busy;
    logic [7:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        z_req, z_we, z_ack, z_err, z_busy;
    logic [7:0]  z_addr;
    logic [15:0] z_wdata, z_rdata;

    mem_bus_responder #(.ADDR_W(8), .DEPTH(D), .WAIT_CYCLES(W)) u_a (
        .clk(clk), .rst(rst), .req(a_req), .we(a_we), .addr(a_addr),
        .wdata(a_wdata), .rdata(a_rdata), .ack(a_ack), .err(a_err),
        .busy(a_busy)
    );

    mem_bus_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_z (
        .clk(clk), .rst(rst), .req(z_req), .we(z_we), .addr(z_addr),
        .wdata(z_wdata), .rdata(z_rdata), .ack(z_ack), .err(z_err),
        .busy(z_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Transaction-level model state
    logic [15:0] mem_m [256];
    bit          known [256];
    logic        exp_ack, exp_err, exp_busy;
    logic [15:0] exp_rdata;
    bit          chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", {31'd0, a_ack}, {31'd0, exp_ack});
            check("err", {31'd0, a_err}, {31'd0, exp_err});
            check("busy", {31'd0, a_busy}, {31'd0, exp_busy});
            check("rdata", {16'd0, a_rdata}, {16'd0, exp_rdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a_we    = 1'($urandom);
        a_addr  = 8'($urandom);
        a_wdata = 16'($urandom);
    endtask

    task automatic do_txn(input bit w, input logic [7:0] ad,
                          input logic [15:0] wd, input int hold,
                          input int abort_at, input bit abort_rst,
                          output logic [15:0] got_rd, output logic got_err);
        a_req   = 1'b1;
        a_we    = w;
        a_addr  = ad;
        a_wdata = wd;
        tick();
        exp_busy = 1'b1;
        exp_ack  = 1'b0;
        for (int k = 1; k <= W; k++) begin
            if (abort_at == k) begin
                a_req = 1'b0;
                if (abort_rst) rst = 1'b1;
                tick();
                rst      = 1'b0;
                exp_busy = 1'b0;
                exp_ack  = 1'b0;
                exp_err  = 1'b0;
                if (abort_rst) exp_rdata = 16'h0000;
                got_rd  = a_rdata;
                got_err = a_err;
                return;
            end
            scramble();
            tick();
        end
        exp_ack = 1'b1;
        if (int'(ad) >= D) begin
            exp_err   = 1'b1;
            exp_rdata = 16'h0000;
        end else begin
            exp_err = 1'b0;
            if (w) begin
                mem_m[ad] = wd;
                known[ad] = 1'b1;
            end else begin
                exp_rdata = mem_m[ad];
            end
        end
        got_rd  = a_rdata;
        got_err = a_err;
        for (int h = 0; h < hold; h++) begin
            scramble();
            tick();
        end
        a_req = 1'b0;
        scramble();
        tick();
        exp_ack  = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b0;
    endtask

    logic [15:0] rd;
    logic        er;
    int          n;

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 16'h0000;
        z_req = 1'b0; z_we = 1'b0; z_addr = 8'h00; z_wdata = 16'h0000;
        repeat (2) tick();
        check("rst_ack", {31'd0, a_ack}, 32'd0);
        check("rst_err", {31'd0, a_err}, 32'd0);
        check("rst_busy", {31'd0, a_busy}, 32'd0);
        check("rst_rdata", {16'd0, a_rdata}, 32'd0);
        check("rst_z_busy", {31'd0, z_busy}, 32'd0);
        rst = 1'b0;

        // Zero-wait build
        z_req = 1'b1; z_we = 1'b1; z_addr = 8'h10; z_wdata = 16'h1234;
        tick();
        check("z_wr_ack", {31'd0, z_ack}, 32'd1);
        z_req = 1'b0;
        tick();
        check("z_wr_ack_fall", {31'd0, z_ack}, 32'd0);
        z_req = 1'b1; z_we = 1'b0; z_wdata = 16'h0000;
        tick();
        check("z_rd_ack", {31'd0, z_ack}, 32'd1);
        check("z_rd_data", {16'd0, z_rdata}, 32'h1234);
        check("z_rd_err", {31'd0, z_err}, 32'd0);
        z_req = 1'b0;
        tick();
        check("z_idle_ack", {31'd0, z_ack}, 32'd0);
        check("z_idle_busy", {31'd0, z_busy}, 32'd0);
        check("z_rdata_keep", {16'd0, z_rdata}, 32'h1234);

        // Latency of the two-wait build, counted from the sampling edge
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'hBEEF;
        n = 0;
        do begin
            tick();
            n++;
            if (!a_ack) check("lat_busy", {31'd0, a_busy}, 32'd1);
        end while (!a_ack && n < 10);
        check("lat_a", n, 32'd3);
        a_req = 1'b0;
        tick();
        check("lat_ack_fall", {31'd0, a_ack}, 32'd0);
        mem_m[8'h10] = 16'hBEEF;
        known[8'h10] = 1'b1;
        exp_ack = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
        exp_rdata = 16'h0000;
        chk_en = 1'b1;

        do_txn(1'b0, 8'h10, 16'h0, 0, 0, 1'b0, rd, er);
        check("lit_rd10", {16'd0, rd}, 32'hBEEF);
        check("lit_rd10_err", {31'd0, er}, 32'd0);

        do_txn(1'b1, 8'h40, 16'h1357, 0, 0, 1'b0, rd, er);
        do_txn(1'b1, 8'hC0, 16'hFFFF, 1, 0, 1'b0, rd, er);
        check("lit_wrC0_err", {31'd0, er}, 32'd1);
        do_txn(1'b0, 8'h40, 16'h0, 0, 0, 1'b0, rd, er);
        check("lit_rd40", {16'd0, rd}, 32'h1357);
        do_txn(1'b0, 8'hC0, 16'h0, 0, 0, 1'b0, rd, er);
        check("lit_rdC0", {16'd0, rd}, 32'h0000);
        check("lit_rdC0_err", {31'd0, er}, 32'd1);

        do_txn(1'b1, 8'h20, 16'hAAAA, 0, 0, 1'b0, rd, er);
        do_txn(1'b1, 8'h20, 16'h5555, 0, 1, 1'b0, rd, er);
        check("lit_abort_busy", {31'd0, a_busy}, 32'd0);
        do_txn(1'b0, 8'h20, 16'h0, 0, 0, 1'b0, rd, er);
        check("lit_abort_rd20", {16'd0, rd}, 32'hAAAA);
        do_txn(1'b1, 8'h20, 16'h6666, 0, 1, 1'b1, rd, er);
        check("lit_rst_ack", {31'd0, a_ack}, 32'd0);
        do_txn(1'b0, 8'h20, 16'h0, 0, 0, 1'b0, rd, er);
        check("lit_rst_rd20", {16'd0, rd}, 32'hAAAA);

        do_txn(1'b0, 8'h10, 16'h0, 5, 0, 1'b0, rd, er);
        do_txn(1'b0, 8'h40, 16'h0, 0, 0, 1'b0, rd, er);
        check("lit_b2b_rd40", {16'd0, rd}, 32'h1357);

        for (int t = 0; t < 300; t++) begin
            bit          w;
            logic [7:0]  ad;
            int          ab;
            w  = 1'($urandom);
            ad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                             : 8'($urandom_range(0, 127));
            if (!w && int'(ad) < D && !known[ad]) w = 1'b1;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, W)) : 0;
            do_txn(w, ad, 16'($urandom), int'($urandom_range(0, 3)), ab,
                   1'($urandom), rd, er);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                scramble();
                tick();
            end
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
